if_fetch_unit: RTL

//  Instruction fetch stage. Supplies the 32-bit inst word (plus its PC) consumed by the decode stage.

---
 rtl/if_fetch_unit_if.sv | 31 +++
 rtl/if_fetch_unit.sv | 127 ++++++++++++
 2 files changed

// File: rtl/if_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response channel,
// redirect input from execute and the instruction handoff to decode.
//   master : the fetch unit (drives imem requests and the inst handoff)
//   slave  : the environment (imem, execute, decode)
interface if_fetch_unit_if #(
    parameter int XLEN = 64
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            inst_valid;
    logic            inst_ready;
    logic [31:0]     inst;
    logic [XLEN-1:0] inst_pc;

    modport master (
        output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, inst_ready
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage.
// Issues in-order word fetches to instruction memory, buffers returned words
// (with their PCs) in a small FIFO for decode, and flushes/re-steers on a
// redirect from execute.
// Ports:
//   clk  - clock, all state on the rising edge
//   rst  - asynchronous reset, active low
//   bus  - if_fetch_unit_if.master: imem req/rsp, redirect, inst handoff
//
// state   | meaning
// S_BOOT  | first cycle after reset release, no request issued
// S_FETCH | normal operation, requests gated by the credit rule
module if_fetch_unit #(
    parameter int              XLEN       = 64,
    parameter logic [XLEN-1:0] RESET_PC   = XLEN'(64'h8000_0000),
    parameter int              FIFO_DEPTH = 2
) (
    input  logic           clk,
    input  logic           rst,
    if_fetch_unit_if.master bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {S_BOOT, S_FETCH} state_t;

    state_t          state;
    state_t          state_nxt;
    logic            req_valid;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] rsp_pc;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   fifo_count;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;

    logic [31:0]     data_mem [FIFO_DEPTH];
    logic [XLEN-1:0] pc_mem   [FIFO_DEPTH];

    logic            req_fire;
    logic            rsp_fire;
    logic            push;
    logic            pop;
    logic            credit_ok;
    logic [CW-1:0]   inflight_nxt;
    logic [XLEN-1:0] target_pc;
    logic            unused_redirect_bits;

    assign unused_redirect_bits = ^bus.redirect_pc[1:0];
    assign target_pc = {bus.redirect_pc[XLEN-1:2], 2'b00};

    // Buffered plus outstanding words may never exceed the FIFO size, so a
    // returning word always has a free slot.
    assign credit_ok = ({1'b0, inflight} + {1'b0, fifo_count}) < (CW+1)'(FIFO_DEPTH);

    assign req_fire = req_valid & bus.imem_req_ready;
    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp_fire = bus.imem_rsp_valid & (inflight != '0);
    assign push     = rsp_fire & (drop_cnt == '0) & ~bus.redirect_valid;
    assign pop      = bus.inst_valid & bus.inst_ready & ~bus.redirect_valid;

    assign inflight_nxt = inflight + CW'(req_fire) - CW'(rsp_fire);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_BOOT;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_valid = 1'b0;
        case (state)
            S_BOOT:  state_nxt = S_FETCH;
            S_FETCH: req_valid = credit_ok;
            default: state_nxt = S_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc   <= RESET_PC;
            rsp_pc     <= RESET_PC;
            inflight   <= '0;
            drop_cnt   <= '0;
            fifo_count <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
        end else begin
            inflight <= inflight_nxt;
            if (bus.redirect_valid) begin
                // Everything still outstanding after this cycle belongs to the
                // old path; in-order return makes a simple count exact.
                fetch_pc   <= target_pc;
                rsp_pc     <= target_pc;
                drop_cnt   <= inflight_nxt;
                fifo_count <= '0;
                rd_ptr     <= '0;
                wr_ptr     <= '0;
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
                if (rsp_fire && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                    rsp_pc <= rsp_pc + XLEN'(4);
                end
                if (pop) rd_ptr <= rd_ptr + AW'(1);
                fifo_count <= fifo_count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= bus.imem_rsp_data;
            pc_mem[wr_ptr]   <= rsp_pc;
        end
    end

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = fetch_pc;
    assign bus.inst_valid     = (fifo_count != '0);
    assign bus.inst           = bus.inst_valid ? data_mem[rd_ptr] : 32'h0000_0013;
    // With the FIFO empty, report the PC the next buffered word will carry.
    assign bus.inst_pc        = bus.inst_valid ? pc_mem[rd_ptr] : rsp_pc;
endmodule
